// File: rtl/usb_pkt_serializer.sv
// USB-style packet serializer: SYNC, PID/~PID, token or data fields and optional CRC, LSB first.
// Define USB_PKT_SERIALIZER_CRC_EN to build the CRC5/CRC16 fields; without it packets end after ENDP/DATA.
module usb_pkt_serializer #(
  parameter int DATA_BYTES = 8,
  parameter int SYNC_BITS  = 8
) (
  input  logic                    clk,
  input  logic                    rst_L,
  input  logic                    pktready,
  input  logic [3:0]              pid,
  input  logic [6:0]              addr,
  input  logic [3:0]              endp,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic                    pause,
  output logic                    outb,
  output logic                    sending,
  output logic                    start,
  output logic                    gotpkt,
  output logic                    done
);

  localparam int DW      = 8 * DATA_BYTES;
  localparam int MAX_A   = (SYNC_BITS > DW) ? SYNC_BITS : DW;
  localparam int MAX_LEN = (MAX_A > 16) ? MAX_A : 16;
  localparam int CW      = $clog2(MAX_LEN) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SYNC, S_PID, S_ADDR, S_ENDP, S_DATA
`ifdef USB_PKT_SERIALIZER_CRC_EN
    , S_CRC5, S_CRC16
`endif
  } state_e;

  typedef enum logic [1:0] {C_HS, C_TOKEN, C_DATA} pkt_class_e;

  state_e          state_q, nxt_state;
  pkt_class_e      cls_q;
  logic [CW-1:0]   cnt_q, field_len;
  logic [3:0]      pid_q;
  logic [6:0]      addr_q;
  logic [3:0]      endp_q;
  logic [DW-1:0]   data_q;
  logic [7:0]      pid_byte;
  logic            last_bit, adv;
`ifdef USB_PKT_SERIALIZER_CRC_EN
  logic [4:0]      crc5_q;
  logic [15:0]     crc16_q;

  // One LFSR step: feedback is the incoming bit XOR the remainder MSB.
  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
    return {c[3:0], 1'b0} ^ ((b ^ c[4]) ? 5'h05 : 5'h00);
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
  endfunction
`endif

  assign pid_byte = {~pid_q, pid_q};
  assign sending  = (state_q != S_IDLE) && (state_q != S_LOAD);
  assign start    = (state_q == S_SYNC);
  assign gotpkt   = (state_q == S_LOAD);
  assign adv      = sending && !pause;
  assign last_bit = (cnt_q == field_len - CW'(1));
  assign done     = adv && last_bit && (nxt_state == S_IDLE);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    outb      = 1'b0;
    field_len = CW'(8);
    nxt_state = S_IDLE;
    case (state_q)
      S_SYNC: begin
        outb      = (cnt_q == CW'(SYNC_BITS - 1));
        field_len = CW'(SYNC_BITS);
        nxt_state = S_PID;
      end
      S_PID: begin
        outb      = pid_byte[cnt_q[2:0]];
        nxt_state = (cls_q == C_TOKEN) ? S_ADDR :
                    (cls_q == C_DATA)  ? S_DATA : S_IDLE;
      end
      S_ADDR: begin
        outb      = addr_q[cnt_q[2:0]];
        field_len = CW'(7);
        nxt_state = S_ENDP;
      end
      S_ENDP: begin
        outb      = endp_q[cnt_q[1:0]];
        field_len = CW'(4);
`ifdef USB_PKT_SERIALIZER_CRC_EN
        nxt_state = S_CRC5;
`endif
      end
      S_DATA: begin
        outb      = data_q[0];
        field_len = CW'(DW);
`ifdef USB_PKT_SERIALIZER_CRC_EN
        nxt_state = S_CRC16;
`endif
      end
`ifdef USB_PKT_SERIALIZER_CRC_EN
      // CRC fields go out as the complemented remainder, MSB of the remainder first.
      S_CRC5: begin
        outb      = ~crc5_q[3'd4 - cnt_q[2:0]];
        field_len = CW'(5);
      end
      S_CRC16: begin
        outb      = ~crc16_q[4'd15 - cnt_q[3:0]];
        field_len = CW'(16);
      end
`endif
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= S_IDLE;
      cls_q   <= C_HS;
      cnt_q   <= '0;
      pid_q   <= '0;
      addr_q  <= '0;
      endp_q  <= '0;
      data_q  <= '0;
`ifdef USB_PKT_SERIALIZER_CRC_EN
      crc5_q  <= '0;
      crc16_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (pktready) state_q <= S_LOAD;
        S_LOAD: begin
          pid_q   <= pid;
          addr_q  <= addr;
          endp_q  <= endp;
          data_q  <= data;
          cnt_q   <= '0;
          state_q <= S_SYNC;
          if (pid == 4'b0001 || pid == 4'b1001 || pid == 4'b1101) cls_q <= C_TOKEN;
          else if (pid == 4'b0011 || pid == 4'b1011)               cls_q <= C_DATA;
          else                                                      cls_q <= C_HS;
`ifdef USB_PKT_SERIALIZER_CRC_EN
          crc5_q  <= 5'h1F;
          crc16_q <= 16'hFFFF;
`endif
        end
        default: if (adv) begin
          cnt_q <= last_bit ? '0 : cnt_q + CW'(1);
          if (state_q == S_DATA) data_q <= data_q >> 1;
`ifdef USB_PKT_SERIALIZER_CRC_EN
          if (state_q == S_ADDR || state_q == S_ENDP) crc5_q <= crc5_step(crc5_q, outb);
          if (state_q == S_DATA) crc16_q <= crc16_step(crc16_q, outb);
`endif
          if (last_bit) state_q <= nxt_state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_pkt_serializer.sv
// Self-checking bench for usb_pkt_serializer: directed and random packets against a bit-queue reference model.
module tb_usb_pkt_serializer;
  localparam int DB = 4;
  localparam int SB = 8;
  localparam int DW = 8 * DB;
`ifdef USB_PKT_SERIALIZER_CRC_EN
  localparam int TOK_LEN = SB + 8 + 11 + 5;
`else
  localparam int TOK_LEN = SB + 8 + 11;
`endif

  logic          clk = 1'b0, rst_L = 1'b0, pktready = 1'b0, pause = 1'b0;
  logic [3:0]    pid = '0, endp = '0;
  logic [6:0]    addr = '0;
  logic [DW-1:0] data = '0;
  logic          outb, sending, start, gotpkt, done;

  always #5 clk = ~clk;

  usb_pkt_serializer #(.DATA_BYTES(DB), .SYNC_BITS(SB)) dut (
    .clk(clk), .rst_L(rst_L), .pktready(pktready), .pid(pid), .addr(addr),
    .endp(endp), .data(data), .pause(pause), .outb(outb), .sending(sending),
    .start(start), .gotpkt(gotpkt), .done(done)
  );

  int total = 0, bad = 0;
  bit exp_q[$];
  bit obs_q[$];
  int n_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void add_bits(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endfunction

  // Polynomial division over the bits from index 'from' onward, then append the complemented remainder MSB first.
  function automatic void add_crc(input int from, input int w, input logic [15:0] poly);
    logic [15:0] mask, rem;
    bit msb;
    int n;
    mask = 16'((32'd1 << w) - 1);
    rem  = mask;
    n    = exp_q.size();
    for (int k = from; k < n; k++) begin
      msb = rem[w-1];
      rem = (rem << 1) & mask;
      if (exp_q[k] ^ msb) rem = rem ^ poly;
    end
    for (int i = w - 1; i >= 0; i--) exp_q.push_back(~rem[i]);
  endfunction

  function automatic void build_exp(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                                    input logic [DW-1:0] d);
    int from;
    exp_q.delete();
    add_bits(64'd1 << (SB - 1), SB);
    add_bits({~p, p}, 8);
    from = exp_q.size();
    if (p == 4'b0001 || p == 4'b1001 || p == 4'b1101) begin
      add_bits(a, 7);
      add_bits(e, 4);
`ifdef USB_PKT_SERIALIZER_CRC_EN
      add_crc(from, 5, 16'h0005);
`endif
    end else if (p == 4'b0011 || p == 4'b1011) begin
      add_bits(d, DW);
`ifdef USB_PKT_SERIALIZER_CRC_EN
      add_crc(from, 16, 16'h8005);
`endif
    end
  endfunction

  // Sends one packet; pauses pl1/pl2 cycles while bit pb1/pb2 is presented; abort_at>=0 pulls reset at that bit.
  task automatic run_pkt(input string name, input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                         input logic [DW-1:0] d, input int pb1, input int pl1, input int pb2, input int pl2,
                         input int abort_at);
    int idx = 0, h1 = 0, h2 = 0, n_done = 0, n_got = 0;
    int bit_err = 0, start_err = 0, done_err = 0;
    bit fin = 0, aborted = 0, pz;
    build_exp(p, a, e, d);
    obs_q.delete();
    n_cyc = 0;
    @(negedge clk);
    pid = p; addr = a; endp = e; data = d; pktready = 1'b1; pause = 1'b0;
    #1 check({name, "_idle_gotpkt"}, gotpkt, 1'b0);
    @(negedge clk);
    #1;
    check({name, "_load_gotpkt"}, gotpkt, 1'b1);
    check({name, "_load_sending"}, sending, 1'b0);
    pktready = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      if (c == 0) begin
        pid = ~p; addr = 7'($urandom); endp = 4'($urandom); data = DW'($urandom);
      end
      pz = 1'b0;
      if (idx == pb1 && h1 < pl1) begin pz = 1'b1; h1++; end
      else if (idx == pb2 && h2 < pl2) begin pz = 1'b1; h2++; end
      pause = pz;
      #1;
      if (idx == abort_at && sending) begin
        rst_L = 1'b0;
        #1;
        check({name, "_rst_outb"}, outb, 1'b0);
        check({name, "_rst_sending"}, sending, 1'b0);
        check({name, "_rst_start"}, start, 1'b0);
        check({name, "_rst_done"}, done, 1'b0);
        check({name, "_rst_gotpkt"}, gotpkt, 1'b0);
        check({name, "_rst_no_done_before"}, n_done, 0);
        @(negedge clk);
        rst_L = 1'b1;
        fin = 1; aborted = 1;
      end else if (!sending) begin
        if (done !== 1'b0) done_err++;
        fin = 1;
      end else begin
        n_cyc++;
        if (idx >= exp_q.size() || outb !== exp_q[idx]) bit_err++;
        if (start !== (idx < SB)) start_err++;
        if (done !== (!pz && idx == exp_q.size() - 1)) done_err++;
        if (done) n_done++;
        if (gotpkt) n_got++;
        if (!pz) begin obs_q.push_back(outb); idx++; end
      end
    end
    pause = 1'b0;
    check({name, "_finished"}, fin, 1'b1);
    if (!aborted) begin
      check({name, "_stream_errs"}, bit_err, 0);
      check({name, "_length"}, idx, exp_q.size());
      check({name, "_start_errs"}, start_err, 0);
      check({name, "_done_errs"}, done_err, 0);
      check({name, "_done_count"}, n_done, 1);
      check({name, "_gotpkt_extra"}, n_got, 0);
    end
  endtask

  initial begin
    logic [63:0] w;
    logic [3:0] pids [8];
    int gap_err, got_cnt, dn_cnt, last_done;
    pids = '{4'b0001, 4'b1001, 4'b1101, 4'b0011, 4'b1011, 4'b0010, 4'b1010, 4'b0101};

    #12;
    check("reset_outb", outb, 1'b0);
    check("reset_sending", sending, 1'b0);
    check("reset_start", start, 1'b0);
    check("reset_gotpkt", gotpkt, 1'b0);
    check("reset_done", done, 1'b0);
    @(negedge clk);
    rst_L = 1'b1;

    run_pkt("ack", 4'b0010, '0, '0, '0, -1, 0, -1, 0, -1);
    w = '0;
    for (int i = 0; i < 16 && i < obs_q.size(); i++) w[i] = obs_q[i];
    check("ack_word", w, 64'hD280);
    check("ack_cycles", n_cyc, 16);

    run_pkt("out", 4'b0001, '0, '0, '0, -1, 0, -1, 0, -1);
    check("out_len", obs_q.size(), TOK_LEN);
`ifdef USB_PKT_SERIALIZER_CRC_EN
    w = '0;
    for (int i = 0; i < 5 && 27 + i < obs_q.size(); i++) w[i] = obs_q[27 + i];
    check("out_crc5", w, 64'h02);
`endif

    run_pkt("data0", 4'b0011, '0, '0, 32'h03020100, -1, 0, -1, 0, -1);
    w = '0;
    for (int i = 0; i < DW && 16 + i < obs_q.size(); i++) w[i] = obs_q[16 + i];
    check("data0_payload", w, 64'h03020100);

    run_pkt("pause", 4'b1001, 7'h5A, 4'hC, '0, SB + 8 + 2, 3, TOK_LEN - 1, 2, -1);
    check("pause_cycles", n_cyc, TOK_LEN + 5);

    for (int r = 0; r < 6; r++)
      run_pkt($sformatf("rand%0d", r), pids[$urandom_range(0, 7)], 7'($urandom), 4'($urandom),
              DW'($urandom), $urandom_range(0, 15), $urandom_range(0, 3), -1, 0, -1);

    run_pkt("abort", 4'b0011, '0, '0, DW'($urandom), -1, 0, -1, 0, SB + 8 + 20);
    run_pkt("after_abort", 4'b1011, '0, '0, DW'($urandom), -1, 0, -1, 0, -1);

    // Back-to-back: pktready held high across three handshake packets.
    gap_err = 0; got_cnt = 0; dn_cnt = 0; last_done = -10;
    pid = 4'b1010;
    pktready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (dn_cnt == 3) pktready = 1'b0;
      #1;
      if (c == last_done + 1 && (sending || gotpkt)) gap_err++;
      if (c == last_done + 2 && dn_cnt < 3 && !gotpkt) gap_err++;
      if (gotpkt && got_cnt > 0 && c != last_done + 2) gap_err++;
      if (gotpkt) got_cnt++;
      if (done) begin dn_cnt++; last_done = c; end
      if (dn_cnt == 3 && c > last_done + 2) break;
    end
    pktready = 1'b0;
    check("b2b_gap_errs", gap_err, 0);
    check("b2b_gotpkt_count", got_cnt, 3);
    check("b2b_done_count", dn_cnt, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
